uz_error_latch: RTL and testbench
=================================

UZ_ERROR_LATCH -- requirements
Module: uz_error_latch

Interface
REQ-001 SHALL have parameter N_ERR, default 32, number of error sources (2..32).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4, consecutive high samples needed to qualify an error (1..15).
REQ-003 SHALL have port s00_axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port s00_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port err_in  in  N_ERR  raw error flags, already synchronous to s00_axi_aclk.
REQ-006 SHALL have port err_mask  in  N_ERR  enable per source from the register block; 1 = enabled.
REQ-007 SHALL have port clr_strobe  in  1  one-cycle clear request from the register block.
REQ-008 SHALL have port clr_mask  in  N_ERR  bits to clear; sampled only when clr_strobe=1.
REQ-009 SHALL have port err_pending  out  N_ERR  sticky latched errors; readable by the register block.
REQ-010 SHALL have port first_err_idx  out  5  index of the error that caused the trip.
REQ-011 SHALL have port first_err_valid  out  1  first_err_idx is meaningful.
REQ-012 SHALL have port err_count  out  16  saturating count of newly latched error events.
REQ-013 SHALL have port trip  out  1  safe-state request to the PWM/power stage; level.
REQ-014 SHALL have port irq  out  1  one-cycle interrupt pulse on trip.

Function
REQ-015 SHALL implement one 4-bit filter counter per source: increments while err_in[i]=1, saturates at FILTER_CYCLES, resets to 0 on any cycle with err_in[i]=0.
REQ-016 SHALL set qualified q[i]=1 when the counter equals FILTER_CYCLES, i.e. after FILTER_CYCLES consecutive edges sampling err_in[i]=1.
REQ-017 SHALL define new[i] = q[i] & err_mask[i] & ~err_pending[i]; err_pending[i] sets on the edge after new[i]=1 (total latency FILTER_CYCLES+1 edges from first high sample).
REQ-018 SHALL use a 2-state FSM: ARMED (trip=0) and TRIPPED (trip=1).
REQ-019 ARMED -> TRIPPED SHALL occur on the edge where any new[i]=1; on that same edge irq=1 for exactly one cycle, first_err_valid=1, first_err_idx = lowest i with new[i]=1.
REQ-020 In TRIPPED, further new bits SHALL OR into err_pending without changing first_err_idx and without another irq.
REQ-021 err_count SHALL increment by 1 on each edge where at least one new[i]=1 (not per bit), saturating at 16'hFFFF.
REQ-022 On clr_strobe=1, err_pending SHALL become (err_pending & ~clr_mask) | (q & err_mask); a still-active enabled source is not cleared and does not increment err_count.
REQ-023 A bit simultaneously newly set and requested for clear SHALL end set (set wins) and SHALL count as a new event.
REQ-024 When err_pending becomes all-zero, FSM SHALL return to ARMED on that edge: trip=0, first_err_valid=0, first_err_idx=0.
REQ-025 err_count SHALL clear to 0 only on clr_strobe=1 with clr_mask all-ones, taking priority over an increment in that cycle.
REQ-026 Masking a source after it latched SHALL NOT clear its err_pending bit; masked sources never set pending.
REQ-027 Bits of err_in/err_mask/clr_mask above N_ERR-1 do not exist; first_err_idx upper bits unused for N_ERR<32 SHALL be 0.

Reset
REQ-028 With s00_axi_aresetn=0 at an edge, all filter counters, err_pending, first_err_idx, first_err_valid, err_count, trip, irq SHALL be 0 and FSM ARMED, regardless of state or inputs, including mid-trip.
REQ-029 After reset release, filtering SHALL restart from zero; an err_in held high through reset latches FILTER_CYCLES+1 edges after release.

Verification (FILTER_CYCLES=4, N_ERR=32)
REQ-030 err_mask=FFFFFFFF, err_in[3] high from edge 0 -> err_pending=00000008, trip=1, irq pulse, first_err_idx=3, err_count=1 at edge 5.
REQ-031 err_in[7] high 3 cycles then low -> no pending, trip stays 0, err_count=0.
REQ-032 err_in[9] and err_in[2] high same cycle -> pending=00000204, first_err_idx=2, err_count=1; later err_in[20] -> pending=00100204, err_count=2, no irq, idx still 2.
REQ-033 Tripped on bit 3 with err_in[3] still high, clr_strobe, clr_mask=FFFFFFFF -> pending stays 00000008, trip=1, err_count=0; drop err_in[3], clear again -> pending=0, trip=0, first_err_valid=0 next edge.
REQ-034 err_mask[5]=0, err_in[5] high 10 cycles -> pending=0, trip=0; assert reset while tripped -> all outputs 0 next edge.

Source files
------------

// File: rtl/uz_error_latch.sv
// Error latch: debounces raw error flags, latches sticky pending bits and
// drives a level trip plus a one-cycle irq toward the PWM/power stage.
module uz_error_latch #(
  parameter int N_ERR         = 32,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  input  logic [N_ERR-1:0] err_in,
  input  logic [N_ERR-1:0] err_mask,
  input  logic             clr_strobe,
  input  logic [N_ERR-1:0] clr_mask,
  output logic [N_ERR-1:0] err_pending,
  output logic [4:0]       first_err_idx,
  output logic             first_err_valid,
  output logic [15:0]      err_count,
  output logic             trip,
  output logic             irq
);

  localparam logic [3:0] FILT_MAX = 4'(FILTER_CYCLES);

  typedef enum logic {ARMED = 1'b0, TRIPPED = 1'b1} state_t;

  state_t           state_r;
  logic [3:0]       filt_cnt_r [N_ERR];
  logic [N_ERR-1:0] pend_r;
  logic [N_ERR-1:0] qual_s;
  logic [N_ERR-1:0] new_s;
  logic [N_ERR-1:0] pend_nxt_s;
  logic             any_new_s;
  logic             clr_all_s;
  logic [4:0]       first_idx_s;
  logic [4:0]       idx_r;
  logic             valid_r;
  logic [15:0]      cnt_r;
  logic             trip_r;
  logic             irq_r;

  function automatic logic [4:0] lowest_idx(input logic [N_ERR-1:0] vec);
    lowest_idx = 5'd0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lowest_idx = 5'(i);
      end
    end
  endfunction

  // Qualification, new-event detection and next pending value.
  always_comb begin
    qual_s = '0;
    for (int i = 0; i < N_ERR; i++) begin
      qual_s[i] = (filt_cnt_r[i] == FILT_MAX);
    end
    new_s       = qual_s & err_mask & ~pend_r;
    any_new_s   = |new_s;
    clr_all_s   = clr_strobe & (&clr_mask);
    first_idx_s = lowest_idx(new_s);
    // A clear never removes a source that is still qualified and enabled.
    if (clr_strobe) begin
      pend_nxt_s = (pend_r & ~clr_mask) | (qual_s & err_mask);
    end else begin
      pend_nxt_s = pend_r | new_s;
    end
  end

  // Per-source saturating debounce counters.
  always_ff @(posedge s00_axi_aclk) begin
    for (int i = 0; i < N_ERR; i++) begin
      if (!s00_axi_aresetn) begin
        filt_cnt_r[i] <= 4'd0;
      end else if (!err_in[i]) begin
        filt_cnt_r[i] <= 4'd0;
      end else if (filt_cnt_r[i] != FILT_MAX) begin
        filt_cnt_r[i] <= filt_cnt_r[i] + 4'd1;
      end else begin
        filt_cnt_r[i] <= filt_cnt_r[i];
      end
    end
  end

  // Pending register, event counter and ARMED/TRIPPED state machine.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_r <= ARMED;
      pend_r  <= '0;
      cnt_r   <= 16'd0;
      idx_r   <= 5'd0;
      valid_r <= 1'b0;
      trip_r  <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      irq_r  <= 1'b0;
      if (clr_all_s) begin
        cnt_r <= 16'd0;
      end else if (any_new_s && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        ARMED: begin
          if (any_new_s) begin
            state_r <= TRIPPED;
            trip_r  <= 1'b1;
            irq_r   <= 1'b1;
            valid_r <= 1'b1;
            idx_r   <= first_idx_s;
          end
        end
        TRIPPED: begin
          if (pend_nxt_s == '0) begin
            state_r <= ARMED;
            trip_r  <= 1'b0;
            valid_r <= 1'b0;
            idx_r   <= 5'd0;
          end
        end
        default: begin
          state_r <= ARMED;
          trip_r  <= 1'b0;
          valid_r <= 1'b0;
          idx_r   <= 5'd0;
        end
      endcase
    end
  end

  assign err_pending     = pend_r;
  assign first_err_idx   = idx_r;
  assign first_err_valid = valid_r;
  assign err_count       = cnt_r;
  assign trip            = trip_r;
  assign irq             = irq_r;

endmodule

// File: tb/tb_uz_error_latch.sv
// Directed bench for uz_error_latch (N_ERR=32, FILTER_CYCLES=4).
module tb_uz_error_latch;

  logic        clk;
  logic        rstn;
  logic [31:0] err_in;
  logic [31:0] err_mask;
  logic        clr_strobe;
  logic [31:0] clr_mask;
  logic [31:0] err_pending;
  logic [4:0]  first_err_idx;
  logic        first_err_valid;
  logic [15:0] err_count;
  logic        trip;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  uz_error_latch #(.N_ERR(32), .FILTER_CYCLES(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rstn),
    .err_in          (err_in),
    .err_mask        (err_mask),
    .clr_strobe      (clr_strobe),
    .clr_mask        (clr_mask),
    .err_pending     (err_pending),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid),
    .err_count       (err_count),
    .trip            (trip),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pend"},  err_pending, 32'h0);
    chk({tag, " trip"},  {31'd0, trip}, 32'h0);
    chk({tag, " irq"},   {31'd0, irq}, 32'h0);
    chk({tag, " cnt"},   {16'd0, err_count}, 32'h0);
    chk({tag, " valid"}, {31'd0, first_err_valid}, 32'h0);
    chk({tag, " idx"},   {27'd0, first_err_idx}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; err_in = 32'h0; err_mask = 32'hFFFF_FFFF;
    clr_strobe = 1'b0; clr_mask = 32'h0;
    step(2);
    chk_all_zero("reset");

    // Single source trips after FILTER_CYCLES+1 edges
    rstn = 1'b1; err_in = 32'h0000_0008;
    step(4);
    chk("t1 pend early", err_pending, 32'h0);
    chk("t1 trip early", {31'd0, trip}, 32'h0);
    step(1);
    chk("t1 pend", err_pending, 32'h0000_0008);
    chk("t1 trip", {31'd0, trip}, 32'h1);
    chk("t1 irq",  {31'd0, irq}, 32'h1);
    chk("t1 idx",  {27'd0, first_err_idx}, 32'd3);
    chk("t1 valid", {31'd0, first_err_valid}, 32'h1);
    chk("t1 cnt",  {16'd0, err_count}, 32'd1);
    step(1);
    chk("t1 irq pulse", {31'd0, irq}, 32'h0);
    chk("t1 trip held", {31'd0, trip}, 32'h1);

    // Clear with source still active: bit stays, count clears
    clr_strobe = 1'b1; clr_mask = 32'hFFFF_FFFF;
    step(1);
    clr_strobe = 1'b0;
    chk("t2 pend kept", err_pending, 32'h0000_0008);
    chk("t2 trip kept", {31'd0, trip}, 32'h1);
    chk("t2 cnt clr",   {16'd0, err_count}, 32'd0);
    err_in = 32'h0;
    step(1);
    clr_strobe = 1'b1;
    step(1);
    clr_strobe = 1'b0;
    chk("t2 pend clr", err_pending, 32'h0);
    chk("t2 trip clr", {31'd0, trip}, 32'h0);
    chk("t2 valid clr", {31'd0, first_err_valid}, 32'h0);
    chk("t2 idx clr",  {27'd0, first_err_idx}, 32'h0);

    // Short glitch never qualifies
    err_in = 32'h0000_0080;
    step(3);
    err_in = 32'h0;
    step(3);
    chk("t3 pend", err_pending, 32'h0);
    chk("t3 trip", {31'd0, trip}, 32'h0);
    chk("t3 cnt",  {16'd0, err_count}, 32'd0);

    // Simultaneous sources, then a later one while tripped
    err_in = 32'h0000_0204;
    step(5);
    chk("t4 pend", err_pending, 32'h0000_0204);
    chk("t4 idx",  {27'd0, first_err_idx}, 32'd2);
    chk("t4 cnt",  {16'd0, err_count}, 32'd1);
    chk("t4 irq",  {31'd0, irq}, 32'h1);
    err_in = 32'h0010_0204;
    step(4);
    chk("t4 pend mid", err_pending, 32'h0000_0204);
    step(1);
    chk("t4 pend2", err_pending, 32'h0010_0204);
    chk("t4 cnt2",  {16'd0, err_count}, 32'd2);
    chk("t4 no irq", {31'd0, irq}, 32'h0);
    chk("t4 idx2",  {27'd0, first_err_idx}, 32'd2);
    err_in = 32'h0;
    step(1);
    clr_strobe = 1'b1; clr_mask = 32'hFFFF_FFFF;
    step(1);
    clr_strobe = 1'b0;
    chk("t4 pend clr", err_pending, 32'h0);
    chk("t4 cnt clr",  {16'd0, err_count}, 32'd0);

    // New bit and partial clear on the same edge: set wins and counts
    err_in = 32'h0000_0008;
    step(5);
    chk("t5 trip", {31'd0, trip}, 32'h1);
    err_in = 32'h0000_0400;
    step(4);
    chk("t5 pend pre", err_pending, 32'h0000_0008);
    clr_strobe = 1'b1; clr_mask = 32'h0000_0408;
    step(1);
    clr_strobe = 1'b0;
    chk("t5 pend", err_pending, 32'h0000_0400);
    chk("t5 cnt",  {16'd0, err_count}, 32'd2);
    chk("t5 idx",  {27'd0, first_err_idx}, 32'd3);
    chk("t5 trip2", {31'd0, trip}, 32'h1);
    chk("t5 no irq", {31'd0, irq}, 32'h0);

    // Masked source never latches; unmasking latches at once
    err_in = 32'h0;
    step(1);
    clr_strobe = 1'b1; clr_mask = 32'hFFFF_FFFF;
    step(1);
    clr_strobe = 1'b0;
    err_mask = 32'hFFFF_FFDF; err_in = 32'h0000_0020;
    step(10);
    chk("t6 masked pend", err_pending, 32'h0);
    chk("t6 masked trip", {31'd0, trip}, 32'h0);
    chk("t6 masked cnt",  {16'd0, err_count}, 32'd0);
    err_mask = 32'hFFFF_FFFF;
    step(1);
    chk("t6 unmask pend", err_pending, 32'h0000_0020);
    chk("t6 unmask idx",  {27'd0, first_err_idx}, 32'd5);
    chk("t6 unmask irq",  {31'd0, irq}, 32'h1);
    err_mask = 32'hFFFF_FFDF;
    step(2);
    chk("t6 remask pend", err_pending, 32'h0000_0020);
    chk("t6 remask trip", {31'd0, trip}, 32'h1);

    // Reset mid-trip, then refilter from zero after release
    rstn = 1'b0;
    step(1);
    chk_all_zero("t7 rst");
    step(2);
    err_mask = 32'hFFFF_FFFF; rstn = 1'b1;
    step(4);
    chk("t7 pend early", err_pending, 32'h0);
    step(1);
    chk("t7 pend", err_pending, 32'h0000_0020);
    chk("t7 trip", {31'd0, trip}, 32'h1);
    chk("t7 irq",  {31'd0, irq}, 32'h1);
    chk("t7 cnt",  {16'd0, err_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
